// File: rtl/intr_req_source.sv
// Per-source interrupt requester: counts edge-detected events and drives a req/ack handshake.
// Optional watchdog flag on a long-held req is built when INTR_REQ_TIMEOUT_EN is defined.
module intr_req_source #(
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evtIn,
  input  logic                 en,
  input  logic                 ack,
  output logic                 req,
  output logic [CNT_WIDTH-1:0] pendCnt,
  output logic                 ovf,
  input  logic                 ovfClr,
  output logic                 timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e               state_q;
  logic                 evt_in_q;
  logic                 req_q;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 inc, dec;

  always_comb begin
    inc    = evtIn & ~evt_in_q & en;
    // ack only counts while a request is actually outstanding
    dec    = ack & (state_q == StReq);
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (ovfClr) ovf_d = 1'b0;
    if (inc && !dec) begin
      if (pend_q == '1) ovf_d = 1'b1;
      else              pend_d = pend_q + 1'b1;
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      evt_in_q <= 1'b0;
      req_q    <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= '0;
    end else begin
      evt_in_q <= evtIn;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (pend_d != '0 && en) begin
            state_q <= StReq;
            req_q   <= 1'b1;
          end
        end
        StReq: begin
          if (ack) begin
            state_q <= StGap;
            req_q   <= 1'b0;
          end
        end
        StGap: begin
          // one low cycle guarantees a visible falling edge between requests
          if (pend_q != '0 && en) begin
            state_q <= StReq;
            req_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req     = req_q;
  assign pendCnt = pend_q;
  assign ovf     = ovf_q;

`ifdef INTR_REQ_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);
  localparam logic [WdWidth-1:0] WdMax  = WdWidth'(TIMEOUT);
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT - 1);

  logic [WdWidth-1:0] wd_q;
  logic               timeout_q;

  // wd_q holds the 1-based index of the current REQ cycle; preloaded to 1 outside REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != StReq)  wd_q <= WdWidth'(1);
      else if (wd_q != WdMax) wd_q <= wd_q + 1'b1;
      if (state_q == StReq && wd_q >= WdLast) timeout_q <= 1'b1;
      else if (ovfClr)                       timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_intr_req_source.sv
// Directed bench for intr_req_source (CNT_WIDTH=2, TIMEOUT=8); expected values worked out by hand.
module tb_intr_req_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       evt_in, en, ack, ovf_clr;
  logic       req, ovf, timeout;
  logic [1:0] pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  intr_req_source #(
    .CNT_WIDTH(2),
    .TIMEOUT  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .evtIn  (evt_in),
    .en     (en),
    .ack    (ack),
    .req    (req),
    .pendCnt(pend_cnt),
    .ovf    (ovf),
    .ovfClr (ovf_clr),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; evt_in = 1'b0; en = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check_eq("rst_req", int'(req), 0);
    check_eq("rst_pend", int'(pend_cnt), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    rst = 1'b1;
    tick();

    // single event, ack after two req cycles
    en = 1'b1; evt_in = 1'b1; tick();
    check_eq("t1_req_rise", int'(req), 1);
    check_eq("t1_pend_1", int'(pend_cnt), 1);
    evt_in = 1'b0; tick();
    check_eq("t1_req_hold", int'(req), 1);
    ack = 1'b1; tick();
    check_eq("t1_req_fall", int'(req), 0);
    check_eq("t1_pend_0", int'(pend_cnt), 0);
    ack = 1'b0; tick(); tick();
    check_eq("t1_req_idle", int'(req), 0);

    // three events two cycles apart, then drained one ack at a time
    for (int i = 0; i < 3; i++) begin
      evt_in = 1'b1; tick();
      evt_in = 1'b0; tick();
    end
    check_eq("t2_pend_peak", int'(pend_cnt), 3);
    check_eq("t2_req_high", int'(req), 1);
    for (int i = 0; i < 3; i++) begin
      tick(); tick();
      ack = 1'b1; tick();
      check_eq("t2_gap_low", int'(req), 0);
      check_eq("t2_pend_dec", int'(pend_cnt), 2 - i);
      ack = 1'b0; tick();
      check_eq("t2_after_gap", int'(req), (i < 2) ? 1 : 0);
    end
    check_eq("t2_ovf", int'(ovf), 0);

    // event edge coincident with ack while pendCnt=1
    evt_in = 1'b1; tick();
    evt_in = 1'b0; tick();
    evt_in = 1'b1; ack = 1'b1; tick();
    check_eq("t3_pend_same", int'(pend_cnt), 1);
    check_eq("t3_req_gap", int'(req), 0);
    evt_in = 1'b0; ack = 1'b0; tick();
    check_eq("t3_req_again", int'(req), 1);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    check_eq("t3_pend_end", int'(pend_cnt), 0);

    // saturation at 3 with no ack
    for (int i = 0; i < 5; i++) begin
      evt_in = 1'b1; tick();
      if (i == 2) check_eq("t4_ovf_not_yet", int'(ovf), 0);
      evt_in = 1'b0; tick();
    end
    check_eq("t4_pend_sat", int'(pend_cnt), 3);
    check_eq("t4_ovf_set", int'(ovf), 1);
    ovf_clr = 1'b1; tick();
    check_eq("t4_ovf_clr", int'(ovf), 0);
    check_eq("t4_pend_kept", int'(pend_cnt), 3);
    evt_in = 1'b1; tick();
    check_eq("t4_set_wins", int'(ovf), 1);
    evt_in = 1'b0; tick();
    check_eq("t4_ovf_clr2", int'(ovf), 0);
    ovf_clr = 1'b0;
    // ack held two cycles: second cycle lands in GAP and is ignored
    ack = 1'b1; tick(); tick();
    check_eq("t4_ack_once_pend", int'(pend_cnt), 2);
    check_eq("t4_ack_once_req", int'(req), 1);
    ack = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin
      ack = 1'b1; tick();
      ack = 1'b0; tick();
    end
    check_eq("t4_drained_pend", int'(pend_cnt), 0);
    check_eq("t4_drained_req", int'(req), 0);

    // enable gating
    en = 1'b0; evt_in = 1'b1; tick();
    evt_in = 1'b0; tick();
    check_eq("t5_dis_req", int'(req), 0);
    check_eq("t5_dis_pend", int'(pend_cnt), 0);
    en = 1'b1; evt_in = 1'b1; tick();
    evt_in = 1'b0; en = 1'b0; tick(); tick();
    check_eq("t5_req_no_en", int'(req), 1);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    check_eq("t5_req_acked", int'(req), 0);
    // en low across GAP parks in IDLE with the count kept
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      evt_in = 1'b1; tick();
      evt_in = 1'b0; tick();
    end
    en = 1'b0; ack = 1'b1; tick();
    ack = 1'b0; tick(); tick();
    check_eq("t5_park_req", int'(req), 0);
    check_eq("t5_park_pend", int'(pend_cnt), 1);
    en = 1'b1; tick();
    check_eq("t5_resume_req", int'(req), 1);
    // asynchronous reset mid-REQ
    #3 rst = 1'b0;
    #1;
    check_eq("t5_async_req", int'(req), 0);
    check_eq("t5_async_pend", int'(pend_cnt), 0);
    tick();
    rst = 1'b1;
    tick();

    // watchdog
    evt_in = 1'b1; tick();
    evt_in = 1'b0;
`ifdef INTR_REQ_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      check_eq("t6_timeout_early", int'(timeout), 0);
      tick();
    end
    check_eq("t6_timeout_set", int'(timeout), 1);
`else
    for (int k = 0; k < 12; k++) tick();
    check_eq("t6_timeout_off", int'(timeout), 0);
`endif
    check_eq("t6_req_held", int'(req), 1);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    check_eq("t6_req_done", int'(req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
